// File: rtl/ibp_pkg.sv
// Shared ibp definitions: command encodings,
// field widths and handshake FSM states.
package ibp_pkg;
  localparam logic cReadCmd  = 1'b1;
  localparam logic cWriteCmd = 1'b0;
  localparam int cAddrW  = 7;
  localparam int cDataW  = 8;
  localparam int cFrameW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    REL  = 2'd3
  } state_e;
endpackage

// File: rtl/spi_pin_sync.sv
// SPI pin synchronizer and edge detector
// running in the system clock domain.
module spi_pin_sync #(
  parameter int cSyncStages = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sclk,
  input  logic i_csn,
  input  logic i_mosi,
  output logic o_sclk_rise,
  output logic o_sclk_fall,
  output logic o_csn_fall,
  output logic o_csn_rise,
  output logic o_mosi_s,
  output logic o_csn_s
);
  logic [cSyncStages-1:0] r_sclk;
  logic [cSyncStages-1:0] r_csn;
  logic [cSyncStages-1:0] r_mosi;
  logic r_sclk_d;
  logic r_csn_d;
  logic w_sclk;
  logic w_csn;

  // sync chains plus one delayed copy for edges
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sclk   <= '0;
      r_csn    <= '1;
      r_mosi   <= '0;
      r_sclk_d <= 1'b0;
      r_csn_d  <= 1'b1;
    end else begin
      r_sclk   <= {r_sclk[cSyncStages-2:0], i_sclk};
      r_csn    <= {r_csn[cSyncStages-2:0], i_csn};
      r_mosi   <= {r_mosi[cSyncStages-2:0], i_mosi};
      r_sclk_d <= w_sclk;
      r_csn_d  <= w_csn;
    end
  end

  assign w_sclk      = r_sclk[cSyncStages-1];
  assign w_csn       = r_csn[cSyncStages-1];
  assign o_sclk_rise = w_sclk & ~r_sclk_d;
  assign o_sclk_fall = ~w_sclk & r_sclk_d;
  assign o_csn_fall  = ~w_csn & r_csn_d;
  assign o_csn_rise  = w_csn & ~r_csn_d;
  assign o_mosi_s    = r_mosi[cSyncStages-1];
  assign o_csn_s     = w_csn;
endmodule

// File: rtl/spi_ibp_master.sv
// SPI mode-0 slave front end that issues one
// ibp four-phase transaction per 16-bit frame.
module spi_ibp_master
  import ibp_pkg::*;
#(
  parameter int         cSyncStages = 2,
  parameter int         cHoldCycles = 2,
  parameter int         cAckTimeout = 32,
  parameter logic [7:0] cRdDefault  = 8'hFF
) (
  input  logic              sys_clk_i,
  input  logic              sys_rstn_i,
  input  logic              spi_sclk_i,
  input  logic              spi_csn_i,
  input  logic              spi_mosi_i,
  output logic              spi_miso_o,
  output logic              spi_miso_oe_o,
  output logic              ibp_cmd,
  output logic [cAddrW-1:0] ibp_addr,
  output logic [cDataW-1:0] ibp_wdata,
  output logic              ibp_valid,
  input  logic              ibp_ack,
  input  logic [cDataW-1:0] ibp_rdata,
  output logic              busy_o,
  output logic              frame_err_o,
  output logic              timeout_o
);
  localparam int cCntW = $clog2(cAckTimeout + 1);

  logic w_sclk_rise, w_sclk_fall;
  logic w_csn_fall, w_csn_rise;
  logic w_mosi_s, w_csn_s;

  logic [4:0]        r_bits;
  logic [7:0]        r_sh;
  logic              r_fcmd;
  logic [cAddrW-1:0] r_faddr;
  logic              r_frame_rd;
  logic              r_ferr;
  logic              r_miso;
  logic [7:0]        r_tx;

  state_e            r_state, w_nxt;
  logic [cCntW-1:0]  r_cnt;
  logic              r_cmd;
  logic [cAddrW-1:0] r_addr;
  logic [cDataW-1:0] r_wdata;
  logic              r_pend, r_pcmd;
  logic [cAddrW-1:0] r_paddr;
  logic [cDataW-1:0] r_pdata;
  logic              r_rd_ok;
  logic [cDataW-1:0] r_rd_byte;
  logic              r_to;

  logic       w_bit_en, w_rd_req, w_wr_req;
  logic       w_issue, w_cap, w_to;
  logic [7:0] w_sh_nxt, w_byte;

  spi_pin_sync #(.cSyncStages(cSyncStages)) u_sync (
    .i_clk       (sys_clk_i),
    .i_rst_n     (sys_rstn_i),
    .i_sclk      (spi_sclk_i),
    .i_csn       (spi_csn_i),
    .i_mosi      (spi_mosi_i),
    .o_sclk_rise (w_sclk_rise),
    .o_sclk_fall (w_sclk_fall),
    .o_csn_fall  (w_csn_fall),
    .o_csn_rise  (w_csn_rise),
    .o_mosi_s    (w_mosi_s),
    .o_csn_s     (w_csn_s)
  );

  assign w_bit_en = w_sclk_rise & ~w_csn_s & ~w_csn_fall
                  & ~w_csn_rise & (r_bits != 5'd16);
  assign w_sh_nxt = {r_sh[6:0], w_mosi_s};
  assign w_rd_req = w_bit_en && r_bits == 5'd7
                  && w_sh_nxt[7] == cReadCmd;
  assign w_wr_req = w_bit_en && r_bits == 5'd15
                  && r_fcmd == cWriteCmd;
  assign w_byte   = r_rd_ok ? r_rd_byte : cRdDefault;

  // frame decoder: bit count, shift, header latch
  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      r_bits     <= '0;
      r_sh       <= '0;
      r_fcmd     <= 1'b0;
      r_faddr    <= '0;
      r_frame_rd <= 1'b0;
      r_ferr     <= 1'b0;
    end else begin
      r_ferr <= 1'b0;
      if (w_csn_fall) begin
        r_bits     <= '0;
        r_frame_rd <= 1'b0;
      end else if (w_csn_rise) begin
        r_bits     <= '0;
        r_frame_rd <= 1'b0;
        r_ferr     <= (r_bits != 5'd16);
      end else if (w_bit_en) begin
        r_bits <= r_bits + 5'd1;
        r_sh   <= w_sh_nxt;
        if (r_bits == 5'd7) begin
          r_fcmd     <= w_sh_nxt[7];
          r_faddr    <= w_sh_nxt[6:0];
          r_frame_rd <= (w_sh_nxt[7] == cReadCmd);
        end
      end
    end
  end

  // MISO: read byte out after the header, else 1
  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      r_miso <= 1'b1;
      r_tx   <= '0;
    end else if (w_csn_rise) begin
      r_miso <= 1'b1;
    end else if (w_sclk_fall && !w_csn_s) begin
      if (r_bits == 5'd8 && r_frame_rd) begin
        r_miso <= w_byte[7];
        r_tx   <= {w_byte[6:0], 1'b1};
      end else if (r_bits > 5'd8 && r_bits < 5'd16
                   && r_frame_rd) begin
        r_miso <= r_tx[7];
        r_tx   <= {r_tx[6:0], 1'b1};
      end else begin
        r_miso <= 1'b1;
      end
    end
  end

  // handshake state, fields, pending slot, capture
  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_cmd     <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_pend    <= 1'b0;
      r_pcmd    <= 1'b0;
      r_paddr   <= '0;
      r_pdata   <= '0;
      r_rd_ok   <= 1'b0;
      r_rd_byte <= '0;
      r_to      <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_to    <= w_to;
      if (w_nxt != r_state || r_state == IDLE)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 1'b1;
      if (w_issue) begin
        r_cmd   <= r_pcmd;
        r_addr  <= r_paddr;
        r_wdata <= r_pdata;
        r_pend  <= 1'b0;
      end
      if (w_cap && r_cmd == cReadCmd) begin
        r_rd_byte <= ibp_rdata;
        r_rd_ok   <= 1'b1;
      end
      if (w_rd_req) begin
        r_pend  <= 1'b1;
        r_pcmd  <= cReadCmd;
        r_paddr <= w_sh_nxt[6:0];
        r_pdata <= '0;
        r_rd_ok <= 1'b0;
      end else if (w_wr_req) begin
        r_pend  <= 1'b1;
        r_pcmd  <= cWriteCmd;
        r_paddr <= r_faddr;
        r_pdata <= w_sh_nxt;
      end
    end
  end

  // handshake next state and strobes
  always_comb begin
    w_nxt   = r_state;
    w_issue = 1'b0;
    w_cap   = 1'b0;
    w_to    = 1'b0;
    unique case (r_state)
      IDLE: if (r_pend && ibp_ack) begin
        w_nxt   = REQ;
        w_issue = 1'b1;
      end
      REQ: if (!ibp_ack) begin
        w_nxt = HOLD;
        w_cap = 1'b1;
      end else if (r_cnt == cCntW'(cAckTimeout - 1)) begin
        w_nxt = IDLE;
        w_to  = 1'b1;
      end
      HOLD: if (r_cnt == cCntW'(cHoldCycles - 1))
        w_nxt = REL;
      REL: if (ibp_ack) begin
        w_nxt = IDLE;
      end else if (r_cnt == cCntW'(cAckTimeout - 1)) begin
        w_nxt = IDLE;
        w_to  = 1'b1;
      end
      default: w_nxt = IDLE;
    endcase
  end

  assign spi_miso_o    = r_miso;
  assign spi_miso_oe_o = ~w_csn_s;
  assign ibp_cmd       = r_cmd;
  assign ibp_addr      = r_addr;
  assign ibp_wdata     = r_wdata;
  assign ibp_valid     = (r_state == REQ) || (r_state == HOLD);
  assign busy_o        = (r_state != IDLE);
  assign frame_err_o   = r_ferr;
  assign timeout_o     = r_to;
endmodule
